mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- FSM controller that sequences the shared multiply/divide kernel datapath: radix-2 Booth multiply and carry-save SRT divide.
- Accepts one operation at a time over a valid/ready handshake and drives the kernel controls: load, iterate, saveReminder, correct.
- Counts iterations and returns completion over a second valid/ready handshake.
- Sits between the issue logic and the kernel/CSA register stage of the Multiply-Division Unit.

Parameters:
PARALLELISM, 32, operand width; multiply takes PARALLELISM iterations, divide takes PARALLELISM+1.
CNT_W, $clog2(PARALLELISM+2), iteration counter width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid_i  input  1  operation request valid.
in_ready_o  output  1  sequencer can accept a request (state IDLE).
opCode_i  input  3  [2]=1 divide / 0 multiply; [1] upper half or remainder select; [0]=1 unsigned.
div_zero_i  input  1  divisor is zero; sampled in LOAD.
rem_neg_i  input  1  partial remainder sign after SAVE_REM; sampled in SAVE_REM.
kill_i  input  1  synchronous abort.
load_o  output  1  load operand registers and clear accumulators.
iter_en_o  output  1  advance one kernel iteration (shift + CSA update).
saveReminder_o  output  1  kernel saveReminder control; forces kernel to output zero.
correct_o  output  1  apply final remainder/quotient correction step.
opCode_o  output  3  opCode latched at accept; stable for the whole operation.
iter_cnt_o  output  CNT_W  remaining iterations.
out_valid_o  output  1  result ready on the datapath.
out_ready_i  input  1  consumer accepts result.
div_zero_o  output  1  qualifies out_valid_o; result is the divide-by-zero default.

Behaviour:
- States: IDLE, LOAD, ITER, SAVE_REM, CORRECT, DONE. Encoding is free.
- Reset:
  - Async to IDLE.
  - Registered outputs reset to 0: opCode_o, iter_cnt_o, div_zero_o.
  - All strobe outputs are 0 in reset.
  - in_ready_o=1 while in IDLE, but no handshake is taken while rst_n=0.
  - Reset mid-operation abandons the operation silently.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: latch opCode_i into opCode_o, clear div_zero_o, go to LOAD.
- LOAD (1 cycle):
  - load_o=1.
  - If opCode_o[2]&&div_zero_i: set div_zero_o=1 and go to DONE.
  - Otherwise load iter_cnt_o with PARALLELISM-1 (multiply) or PARALLELISM (divide), then go to ITER.
  - div_zero_i is ignored for multiply.
- ITER:
  - iter_en_o=1 every cycle.
  - iter_cnt_o decrements each cycle.
  - When iter_cnt_o==0 this is the last iteration: next state is SAVE_REM for divide, DONE for multiply.
  - No wrap-around; the counter is never decremented at 0.
- SAVE_REM (divide only, 1 cycle):
  - saveReminder_o=1.
  - Sample rem_neg_i: if 1 go to CORRECT, else go to DONE.
- CORRECT (1 cycle): correct_o=1, then go to DONE.
- DONE:
  - out_valid_o=1, held until out_ready_i=1.
  - On acceptance, return to IDLE.
  - Datapath controls are all 0 and opCode_o is held.
  - in_ready_o=0, so a new request cannot be accepted in the same cycle as result acceptance.
- Latency, counting the accept edge as cycle 0, to first out_valid_o cycle:
  - Multiply: PARALLELISM+2.
  - Divide: PARALLELISM+4 without correction, PARALLELISM+5 with correction.
  - Divide-by-zero: 2.
- kill_i:
  - In any non-IDLE state, go to IDLE next cycle; no out_valid_o is produced; div_zero_o is cleared.
  - kill_i beats simultaneous out_ready_i in DONE: the result is dropped.
  - kill_i in IDLE blocks acceptance that cycle (in_ready_o is forced 0 while kill_i=1).
- Mutual exclusion: at most one of load_o, iter_en_o, saveReminder_o, correct_o is high in any cycle. Assert this.
- opCode_i changes after acceptance have no effect.

Test Plan:
- Unsigned multiply: opCode=3'b001, PARALLELISM=32, accept at cycle 0, out_ready_i=1 → load_o at cycle 1; iter_en_o cycles 2..33 (32 pulses); out_valid_o at cycle 34; in_ready_o back at cycle 35.
- Signed divide, rem_neg_i=0: opCode=3'b100 → 33 iter_en_o pulses; saveReminder_o at cycle 35; no correct_o; out_valid_o at cycle 36.
- Divide with rem_neg_i=1 in SAVE_REM → correct_o at cycle 36; out_valid_o at cycle 37.
- Divide-by-zero: opCode=3'b101, div_zero_i=1 in LOAD → zero iter_en_o pulses; out_valid_o and div_zero_o at cycle 2. Same stimulus with opCode=3'b001 (multiply) → div_zero_i ignored, normal 34-cycle latency.
- Backpressure/kill:
  - Hold out_ready_i=0 for 5 cycles in DONE → out_valid_o stays high and in_ready_o stays 0.
  - kill_i together with out_ready_i → IDLE next cycle, no handshake completes.
  - kill_i at iteration 10 → IDLE next cycle, no further strobes.
- Async reset: drop rst_n mid-ITER, asynchronous to clk → all strobes 0 immediately, opCode_o=0, iter_cnt_o=0. After release, a new multiply completes with nominal latency.

Source files
------------

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iteration sequencer for the shared multiply/divide kernel
module mdu_sequencer #(
    parameter int PARALLELISM = 32,
    parameter int CNT_W       = $clog2(PARALLELISM + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       opCode_i,
    input  logic             div_zero_i,
    input  logic             rem_neg_i,
    input  logic             kill_i,
    output logic             load_o,
    output logic             iter_en_o,
    output logic             saveReminder_o,
    output logic             correct_o,
    output logic [2:0]       opCode_o,
    output logic [CNT_W-1:0] iter_cnt_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             div_zero_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_SAVE_REM,
        S_CORRECT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        op_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              dz_nxt;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operation context: latched opcode, remaining iterations, divide-by-zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCode_o   <= 3'b000;
            iter_cnt_o <= '0;
            div_zero_o <= 1'b0;
        end else begin
            opCode_o   <= op_nxt;
            iter_cnt_o <= cnt_nxt;
            div_zero_o <= dz_nxt;
        end
    end

    // Next-state, context updates and kernel strobes decoded from the current state.
    always_comb begin
        state_nxt      = state;
        op_nxt         = opCode_o;
        cnt_nxt        = iter_cnt_o;
        dz_nxt         = div_zero_o;
        in_ready_o     = 1'b0;
        load_o         = 1'b0;
        iter_en_o      = 1'b0;
        saveReminder_o = 1'b0;
        correct_o      = 1'b0;
        out_valid_o    = 1'b0;

        case (state)
            S_IDLE: begin
                // kill_i blocks acceptance so an abort never races a new request.
                in_ready_o = !kill_i;
                if (in_valid_i && !kill_i) begin
                    op_nxt    = opCode_i;
                    dz_nxt    = 1'b0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_o = 1'b1;
                if (opCode_o[2] && div_zero_i) begin
                    dz_nxt    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    // Divide needs one extra iteration to produce the final quotient bit.
                    cnt_nxt   = opCode_o[2] ? CNT_W'(PARALLELISM) : CNT_W'(PARALLELISM - 1);
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                iter_en_o = 1'b1;
                if (iter_cnt_o == '0) begin
                    state_nxt = opCode_o[2] ? S_SAVE_REM : S_DONE;
                end else begin
                    cnt_nxt = iter_cnt_o - CNT_W'(1);
                end
            end
            S_SAVE_REM: begin
                saveReminder_o = 1'b1;
                state_nxt      = rem_neg_i ? S_CORRECT : S_DONE;
            end
            S_CORRECT: begin
                correct_o = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                // Valid is withdrawn under kill so the consumer never sees a completed handshake.
                out_valid_o = !kill_i;
                if (out_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (kill_i && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            dz_nxt    = 1'b0;
        end
    end

    // At most one kernel control may be active in any cycle.
    strobe_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({load_o, iter_en_o, saveReminder_o, correct_o}));

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - randomized and directed bench for mdu_sequencer
module tb_mdu_sequencer;

    localparam int P  = 32;
    localparam int CW = $clog2(P + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opcode_in;
    logic          div_zero_in;
    logic          rem_neg;
    logic          kill;
    logic          load;
    logic          iter_en;
    logic          save_rem;
    logic          correct;
    logic [2:0]    opcode_out;
    logic [CW-1:0] iter_cnt;
    logic          out_valid;
    logic          out_ready;
    logic          div_zero_out;

    int tests    = 0;
    int failures = 0;

    mdu_sequencer #(.PARALLELISM(P)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .opCode_i       (opcode_in),
        .div_zero_i     (div_zero_in),
        .rem_neg_i      (rem_neg),
        .kill_i         (kill),
        .load_o         (load),
        .iter_en_o      (iter_en),
        .saveReminder_o (save_rem),
        .correct_o      (correct),
        .opCode_o       (opcode_out),
        .iter_cnt_o     (iter_cnt),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .div_zero_o     (div_zero_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {load, iter_en, save_rem, correct, out_valid, in_ready};
    endfunction

    // Runs one operation; cycle k counts edges after the accept edge (cycle 0).
    // Expected timeline comes from the operation rules: 1 load, n iterations,
    // optional save/correct, then DONE until accepted (or killed at kill_at).
    task automatic do_op(input logic [2:0] op, input logic dz, input logic rn,
                         input int wait_n, input int kill_at);
        bit       dzp;
        int       n;
        int       ds;
        int       k;
        bit       fin;
        bit       killed;
        bit       e_done;
        logic [5:0] e;
        dzp    = op[2] && dz;
        n      = op[2] ? P + 1 : P;
        ds     = dzp ? 2 : (!op[2] ? n + 2 : (rn ? n + 4 : n + 3));
        fin    = 1'b0;
        killed = 1'b0;
        k      = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        opcode_in   = op;
        div_zero_in = dz;
        rem_neg     = rn;
        kill        = 1'b0;
        out_ready   = 1'b0;
        #1 chk("accept_ready", {31'd0, in_ready}, 32'd1);
        while (!fin) begin
            @(negedge clk);
            k++;
            in_valid  = 1'($urandom_range(0, 1));
            opcode_in = 3'($urandom);
            kill      = (k == kill_at);
            out_ready = (k >= ds + wait_n) || ((k < ds) && ($urandom_range(0, 1) == 1));
            #1;
            e_done = (k >= ds);
            e[5] = (k == 1);
            e[4] = !dzp && (k >= 2) && (k <= n + 1);
            e[3] = !dzp && op[2] && (k == n + 2);
            e[2] = !dzp && op[2] && rn && (k == n + 3);
            e[1] = e_done && !kill;
            e[0] = 1'b0;
            chk($sformatf("strobes_c%0d", k), {26'd0, strobes()}, {26'd0, e});
            chk($sformatf("opcode_c%0d", k), {29'd0, opcode_out}, {29'd0, op});
            chk($sformatf("div_zero_c%0d", k), {31'd0, div_zero_out}, {31'd0, dzp && (k >= 2)});
            if (e[4]) chk($sformatf("iter_cnt_c%0d", k), 32'(iter_cnt), 32'(n + 1 - k));
            if (kill) begin
                fin    = 1'b1;
                killed = 1'b1;
            end else if (k >= ds + wait_n) begin
                fin = 1'b1;
            end
            if (k > 200) begin
                tests++;
                failures++;
                $error("FAIL timeout observed=%0d expected=%0d", k, ds);
                fin = 1'b1;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        kill      = 1'b0;
        out_ready = 1'b0;
        #1 chk("idle_after", {26'd0, strobes()}, 32'h1);
        if (killed) chk("dz_cleared", {31'd0, div_zero_out}, 32'd0);
        else        chk("opcode_held", {29'd0, opcode_out}, {29'd0, op});
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        opcode_in   = 3'b111;
        div_zero_in = 1'b0;
        rem_neg     = 1'b0;
        kill        = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {26'd0, strobes()}, 32'h1);
        chk("rst_opcode", {29'd0, opcode_out}, 32'd0);
        chk("rst_cnt", 32'(iter_cnt), 32'd0);
        chk("rst_dz", {31'd0, div_zero_out}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        do_op(3'b001, 1'b0, 1'b0, 0, 0);
        do_op(3'b100, 1'b0, 1'b0, 0, 0);
        do_op(3'b110, 1'b0, 1'b1, 0, 0);
        do_op(3'b101, 1'b1, 1'b0, 0, 0);
        do_op(3'b001, 1'b1, 1'b0, 0, 0);
        do_op(3'b000, 1'b0, 1'b0, 5, 0);
        do_op(3'b011, 1'b0, 1'b0, 0, P + 2);
        do_op(3'b010, 1'b0, 1'b0, 0, 12);
        do_op(3'b111, 1'b1, 1'b0, 3, 2);

        // kill in IDLE blocks acceptance
        @(negedge clk);
        in_valid  = 1'b1;
        kill      = 1'b1;
        opcode_in = 3'b100;
        #1 chk("kill_idle_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        #1 chk("kill_idle_noload", {26'd0, strobes()}, 32'h1);

        // asynchronous reset in the middle of the iterations
        @(negedge clk);
        in_valid  = 1'b1;
        opcode_in = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_strobes", {26'd0, strobes()}, 32'h1);
        chk("arst_opcode", {29'd0, opcode_out}, 32'd0);
        chk("arst_cnt", 32'(iter_cnt), 32'd0);
        #3 rst_n = 1'b1;
        do_op(3'b001, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(3'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
